// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and digit helpers for the four-digit display scanner
package disp_pkg;

    localparam int N_DIGITS = 4;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_idx_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef struct packed {
        logic [N_DIGITS*4-1:0] bcd;
        logic [N_DIGITS-1:0]   dp;
    } disp_word_t;

    function automatic bcd_t digit_of(input logic [N_DIGITS*4-1:0] bcd, input digit_idx_t k);
        return bcd[4*k +: 4];
    endfunction

    // True when digit k and every more-significant digit are zero.
    function automatic logic upper_zero(input logic [N_DIGITS*4-1:0] bcd, input digit_idx_t k);
        logic z;
        z = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(k) && bcd[4*j +: 4] != 4'd0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/disp_refresh_tick.sv
// rtl/disp_refresh_tick.sv - free-running modulo-DIV counter with terminal-count tick
module disp_refresh_tick #(
    parameter int DIV = 100000,
    parameter int W   = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tc;

    always_comb begin
        tc    = (cnt_q == W'(DIV - 1));
        cnt_d = tc ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign tc_o       = tc;

endmodule

// File: rtl/disp_scan4.sv
// rtl/disp_scan4.sv - four-digit time-multiplexed 7-segment scanner with frame-atomic loads
module disp_scan4
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_en,
    output logic [3:0]  bcd_out,
    output logic        blank,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tc;

    disp_refresh_tick #(.DIV(REFRESH_DIV), .W(CW)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .cnt_o      (cnt_q),
        .cnt_next_o (cnt_d),
        .tc_o       (tc)
    );

    digit_idx_t idx_q, idx_d;
    disp_word_t active_q, active_d;
    disp_word_t shadow_q, shadow_d;
    logic       pending_q, pending_d;
    logic       boundary;
    logic       dead_d;
    bcd_t       nib_d;

    logic [3:0] bcd_out_q;
    logic       blank_nib_q;
    logic       lz_q;
    logic [3:0] an_q;
    logic       dp_q;
    logic       frame_done_q;

    // Loads land in the shadow and only reach the display at a frame boundary,
    // except a load coinciding with the boundary, which goes straight through.
    always_comb begin
        boundary  = (idx_q == digit_idx_t'(N_DIGITS - 1)) && tc;
        idx_d     = tc ? idx_q + 2'd1 : idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d  = '{bcd: bcd_in, dp: dp_in};
            pending_d = 1'b1;
        end
        if (boundary) begin
            if (load) begin
                active_d = '{bcd: bcd_in, dp: dp_in};
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end
        nib_d  = digit_of(active_d.bcd, idx_d);
        dead_d = (cnt_d < CW'(DEAD_CYC));
    end

    // Output registers are computed from next state so they line up with cnt/idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            bcd_out_q    <= 4'd0;
            blank_nib_q  <= 1'b1;
            lz_q         <= 1'b0;
            an_q         <= 4'b1111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            bcd_out_q    <= nib_d;
            blank_nib_q  <= (nib_d > BCD_MAX);
            lz_q         <= (idx_d != '0) && upper_zero(active_d.bcd, idx_d);
            an_q         <= dead_d ? 4'b1111 : ~(4'b0001 << idx_d);
            dp_q         <= dead_d ? 1'b1 : ~active_d.dp[idx_d];
            frame_done_q <= boundary;
        end
    end

    assign bcd_out    = bcd_out_q;
    assign blank      = blank_nib_q | (blank_en & lz_q);
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan4.sv
// tb/tb_disp_scan4.sv - scoreboard bench for disp_scan4 with an 8-cycle slot
module tb_disp_scan4;

    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_en;
    logic [3:0]  bcd_out;
    logic        blank;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    disp_scan4 #(.REFRESH_DIV(DIV), .DEAD_CYC(DEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_en   (blank_en),
        .bcd_out    (bcd_out),
        .blank      (blank),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    logic [10:0] sb_q[$];
    logic [10:0] exp_v;
    logic [15:0] cur_w, nxt_w;
    logic [3:0]  cur_dp, nxt_dp;
    logic        nxt_v;
    logic        ben, ben_nxt;

    localparam logic [10:0] RESET_VEC = {4'h0, 1'b1, 4'b1111, 1'b1, 1'b0};

    function automatic logic [10:0] dut_vec();
        return {bcd_out, blank, an, dp, frame_done};
    endfunction

    // Expected {bcd_out, blank, an, dp, frame_done} at frame position pos.
    function automatic logic [10:0] exp_entry(input logic [15:0] w, input logic [3:0] d,
                                              input logic b, input int pos, input logic fd0);
        int          k;
        int          c;
        logic [15:0] rest;
        logic [3:0]  nib;
        logic        bl;
        logic [3:0]  a;
        logic        p;
        k    = pos / DIV;
        c    = pos % DIV;
        rest = w >> (4 * k);
        nib  = rest[3:0];
        bl   = (nib > 4'd9) || (b && k != 0 && rest == 16'd0);
        a    = (c < DEAD) ? 4'b1111 : ~(4'b0001 << k);
        p    = (c < DEAD) ? 1'b1 : ~d[k];
        return {nib, bl, a, p, fd0 && (pos == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        load = 1'b0;
        repeat (n) step();
        rst      = 1'b0;
        blank_en = 1'b0;
        ben      = 1'b0;
        ben_nxt  = 1'b0;
        cur_w    = 16'h0;
        cur_dp   = 4'h0;
        nxt_v    = 1'b0;
        t        = 0;
        sb_q.delete();
        for (int p = 1; p < FRAME; p++) sb_q.push_back(exp_entry(cur_w, cur_dp, ben, p, 1'b0));
    endtask

    // Drives one cycle; at the boundary cycle the next frame's expectations are queued.
    task automatic drive_cycle(input logic ld, input logic [15:0] w, input logic [3:0] d);
        load   = ld;
        bcd_in = w;
        dp_in  = d;
        if (ld) begin
            nxt_w  = w;
            nxt_dp = d;
            nxt_v  = 1'b1;
        end
        if (t % FRAME == FRAME - 1) begin
            if (nxt_v) begin
                cur_w  = nxt_w;
                cur_dp = nxt_dp;
                nxt_v  = 1'b0;
            end
            ben      = ben_nxt;
            blank_en = ben;
            for (int p = 0; p < FRAME; p++) sb_q.push_back(exp_entry(cur_w, cur_dp, ben, p, 1'b1));
        end
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values got=%h expected=%h", dut_vec(), RESET_VEC);
        end
        for (int c = 0; c < FRAME; c++) begin
            drive_cycle(1'b0, 16'h0, 4'h0);
            exp_v = sb_q.pop_front();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL reset_frame t=%0d got=%h expected=%h", t, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_load_midframe();
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == DIV + 3) drive_cycle(1'b1, 16'h1234, 4'h0);
            else drive_cycle(1'b0, 16'h0, 4'h0);
            exp_v = sb_q.pop_front();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL load_midframe t=%0d got=%h expected=%h", t, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_blanking();
        ben_nxt = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == 5) drive_cycle(1'b1, 16'h0050, 4'h0);
            else if (c == FRAME + 5) drive_cycle(1'b1, 16'h0000, 4'h0);
            else drive_cycle(1'b0, 16'h0, 4'h0);
            exp_v = sb_q.pop_front();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL blanking t=%0d got=%h expected=%h", t, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_dp_on_blank();
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c == 3) drive_cycle(1'b1, 16'h0A00, 4'b0100);
            else drive_cycle(1'b0, 16'h0, 4'h0);
            exp_v = sb_q.pop_front();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL dp_on_blank t=%0d got=%h expected=%h", t, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_boundary();
        ben_nxt = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c == FRAME - 1) drive_cycle(1'b1, 16'h0007, 4'h0);
            else if (c == FRAME + 4) drive_cycle(1'b1, 16'h0001, 4'h0);
            else if (c == FRAME + 20) drive_cycle(1'b1, 16'h0002, 4'h0);
            else drive_cycle(1'b0, 16'h0, 4'h0);
            exp_v = sb_q.pop_front();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL boundary t=%0d got=%h expected=%h", t, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int c = 0; c < 20; c++) begin
            if (c == 5) drive_cycle(1'b1, 16'h9876, 4'hF);
            else drive_cycle(1'b0, 16'h0, 4'h0);
        end
        apply_reset(1);
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_values got=%h expected=%h", dut_vec(), RESET_VEC);
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            drive_cycle(1'b0, 16'h0, 4'h0);
            exp_v = sb_q.pop_front();
            checks++;
            if (dut_vec() !== exp_v) begin
                errors++;
                $display("FAIL reset_midframe t=%0d got=%h expected=%h", t, dut_vec(), exp_v);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0;
        dp_in    = 4'h0;
        blank_en = 1'b0;
        apply_reset(3);
        test_reset();
        test_load_midframe();
        test_blanking();
        test_dp_on_blank();
        test_boundary();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
